// File: rtl/interrupt_ack_sequencer_if.sv
// Signal bundle between the interrupt acknowledge sequencer and its neighbours:
// priority resolver, IRR, data-bus buffer and the ICW/OCW control registers.
interface interrupt_ack_sequencer_if;
    logic [7:0] interrupt;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       auto_eoi;
    logic       eoi_cmd_valid;
    logic [2:0] eoi_cmd;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] in_service_register;
    logic [2:0] priority_rotate;
    logic [7:0] clear_irr;
    logic [7:0] data_out;
    logic       data_out_en;

    modport master (
        output interrupt, inta_n, vector_base, auto_eoi, eoi_cmd_valid, eoi_cmd, eoi_level,
        input  int_out, in_service_register, priority_rotate, clear_irr, data_out, data_out_en
    );

    modport slave (
        input  interrupt, inta_n, vector_base, auto_eoi, eoi_cmd_valid, eoi_cmd, eoi_level,
        output int_out, in_service_register, priority_rotate, clear_irr, data_out, data_out_en
    );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// INT/INTA (8086 two-pulse) responder owning the in-service register and OCW2 EOI/rotate decode.
// Optional feature: define AEOI_ROTATE_EN to enable rotate-in-automatic-EOI (OCW2 100/000).
module interrupt_ack_sequencer #(
    parameter int         NUM_IRQ      = 8,
    parameter logic [2:0] RESET_ROTATE = 3'b111
) (
    input logic                      clock,
    input logic                      reset_n,
    interrupt_ack_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT2, ACK2} state_t;

    state_t               state_q, state_d;
    logic                 inta_n_p1;
    logic                 inta_fall, inta_rise;
    logic                 int_out_q, int_out_d;
    logic [2:0]           level_q, level_d;
    logic                 spurious_q, spurious_d;
    logic [NUM_IRQ-1:0]   clear_irr_q, clear_irr_d;
    logic [7:0]           data_out_q, data_out_d;
    logic                 data_out_en_q, data_out_en_d;
    logic [NUM_IRQ-1:0]   isr_q, isr_d, isr_set, eoi_clr;
    logic [2:0]           rotate_q, rotate_d;
    logic                 aeoi_fire;
    logic [3:0]           highest;
`ifdef AEOI_ROTATE_EN
    logic                 aeoi_rotate_q, aeoi_rotate_d;
`endif

    function automatic logic [NUM_IRQ-1:0] level_bit(input logic [2:0] lvl);
        level_bit      = '0;
        level_bit[lvl] = 1'b1;
    endfunction

    function automatic logic [2:0] encode(input logic [NUM_IRQ-1:0] req);
        encode = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (req[i]) encode = 3'(i);
    endfunction

    // {found, level}; scanning downward lets the level nearest rot+1 be the last one written.
    function automatic logic [3:0] highest_in_service(input logic [NUM_IRQ-1:0] isr,
                                                      input logic [2:0] rot);
        logic [2:0] idx;
        highest_in_service = 4'b0;
        for (int i = NUM_IRQ; i >= 1; i--) begin
            idx = rot + 3'(i);
            if (isr[idx]) highest_in_service = {1'b1, idx};
        end
    endfunction

    // inta_n is synchronous to clock, so one register suffices for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) inta_n_p1 <= 1'b1;
        else          inta_n_p1 <= bus.inta_n;
    end

    assign inta_fall = inta_n_p1 & ~bus.inta_n;
    assign inta_rise = ~inta_n_p1 & bus.inta_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        int_out_d     = int_out_q;
        level_d       = level_q;
        spurious_d    = spurious_q;
        clear_irr_d   = '0;
        data_out_d    = data_out_q;
        data_out_en_d = data_out_en_q;
        isr_set       = '0;
        aeoi_fire     = 1'b0;
        case (state_q)
            IDLE: if (bus.interrupt != '0) begin
                state_d   = REQ;
                int_out_d = 1'b1;
            end
            REQ: if (inta_fall) begin
                state_d   = ACK1;
                int_out_d = 1'b0;
                // The request may have been withdrawn while INT was pending: answer with level 7.
                if (bus.interrupt != '0) begin
                    level_d     = encode(bus.interrupt);
                    spurious_d  = 1'b0;
                    isr_set     = level_bit(encode(bus.interrupt));
                    clear_irr_d = level_bit(encode(bus.interrupt));
                end else begin
                    level_d    = 3'd7;
                    spurious_d = 1'b1;
                end
            end
            ACK1: if (inta_rise) state_d = WAIT2;
            WAIT2: if (inta_fall) begin
                state_d       = ACK2;
                data_out_d    = {bus.vector_base, level_q};
                data_out_en_d = 1'b1;
            end
            ACK2: if (inta_rise) begin
                state_d       = IDLE;
                data_out_en_d = 1'b0;
                aeoi_fire     = bus.auto_eoi & ~spurious_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // An explicit OCW2 rotate takes precedence over an AEOI rotate landing in the same cycle.
    always_comb begin
        eoi_clr  = '0;
        rotate_d = rotate_q;
        highest  = highest_in_service(isr_q, rotate_q);
`ifdef AEOI_ROTATE_EN
        aeoi_rotate_d = aeoi_rotate_q;
        if (aeoi_fire && aeoi_rotate_q) rotate_d = level_q;
`endif
        if (aeoi_fire) eoi_clr = level_bit(level_q);
        if (bus.eoi_cmd_valid) begin
            case (bus.eoi_cmd)
                3'b001: if (highest[3]) eoi_clr = eoi_clr | level_bit(highest[2:0]);
                3'b011: eoi_clr = eoi_clr | level_bit(bus.eoi_level);
                3'b101: if (highest[3]) begin
                    eoi_clr  = eoi_clr | level_bit(highest[2:0]);
                    rotate_d = highest[2:0];
                end
                3'b111: begin
                    eoi_clr  = eoi_clr | level_bit(bus.eoi_level);
                    rotate_d = bus.eoi_level;
                end
                3'b110: rotate_d = bus.eoi_level;
`ifdef AEOI_ROTATE_EN
                3'b100: aeoi_rotate_d = 1'b1;
                3'b000: aeoi_rotate_d = 1'b0;
`endif
                default: ;
            endcase
        end
        isr_d = (isr_q & ~eoi_clr) | isr_set;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            int_out_q     <= 1'b0;
            level_q       <= 3'd0;
            spurious_q    <= 1'b0;
            clear_irr_q   <= '0;
            data_out_q    <= 8'h00;
            data_out_en_q <= 1'b0;
            isr_q         <= '0;
            rotate_q      <= RESET_ROTATE;
        end else begin
            int_out_q     <= int_out_d;
            level_q       <= level_d;
            spurious_q    <= spurious_d;
            clear_irr_q   <= clear_irr_d;
            data_out_q    <= data_out_d;
            data_out_en_q <= data_out_en_d;
            isr_q         <= isr_d;
            rotate_q      <= rotate_d;
        end
    end

`ifdef AEOI_ROTATE_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) aeoi_rotate_q <= 1'b0;
        else          aeoi_rotate_q <= aeoi_rotate_d;
    end
`endif

    assign bus.int_out             = int_out_q;
    assign bus.in_service_register = isr_q;
    assign bus.priority_rotate     = rotate_q;
    assign bus.clear_irr           = clear_irr_q;
    assign bus.data_out            = data_out_q;
    assign bus.data_out_en         = data_out_en_q;
endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Scoreboard bench for interrupt_ack_sequencer: directed scenarios followed by random
// acknowledge/OCW2 traffic against a transaction-level reference model.
module tb_interrupt_ack_sequencer;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    interrupt_ack_sequencer_if bus ();

    interrupt_ack_sequencer #(.NUM_IRQ(8), .RESET_ROTATE(3'b111)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int         n_vec = 0;
    int         n_miscmp = 0;
    logic [7:0] exp_clr_q[$];
    logic [7:0] exp_vec_q[$];
    logic [7:0] m_isr;
    int         m_rot;
    bit         m_flag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic void model_reset();
        m_isr  = 8'h00;
        m_rot  = 7;
        m_flag = 1'b0;
    endfunction

    // One clock's worth of ISR/rotate effects: new in-service level, OCW2 write, AEOI release.
    function automatic void model_step(input int set_lvl, input bit ocw, input logic [2:0] cmd,
                                       input logic [2:0] lvl, input int aeoi_lvl);
        logic [7:0] clr;
        int         hi;
        clr = 8'h00;
        hi  = -1;
        for (int k = 1; k <= 8; k++)
            if (hi < 0 && m_isr[(m_rot + k) % 8]) hi = (m_rot + k) % 8;
        if (aeoi_lvl >= 0) begin
            clr[aeoi_lvl] = 1'b1;
`ifdef AEOI_ROTATE_EN
            if (m_flag) m_rot = aeoi_lvl;
`endif
        end
        if (ocw) begin
            case (cmd)
                3'b001: if (hi >= 0) clr[hi] = 1'b1;
                3'b011: clr[lvl] = 1'b1;
                3'b101: if (hi >= 0) begin clr[hi] = 1'b1; m_rot = hi; end
                3'b111: begin clr[lvl] = 1'b1; m_rot = int'(lvl); end
                3'b110: m_rot = int'(lvl);
`ifdef AEOI_ROTATE_EN
                3'b100: m_flag = 1'b1;
                3'b000: m_flag = 1'b0;
`endif
                default: ;
            endcase
        end
        m_isr = m_isr & ~clr;
        if (set_lvl >= 0) m_isr[set_lvl] = 1'b1;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_isr"}, 32'(bus.in_service_register), 32'(m_isr));
        check({tag, "_rotate"}, 32'(bus.priority_rotate), 32'(m_rot));
    endtask

    task automatic do_ocw(input logic [2:0] cmd, input logic [2:0] lvl);
        bus.eoi_cmd_valid = 1'b1;
        bus.eoi_cmd       = cmd;
        bus.eoi_level     = lvl;
        tick(1);
        bus.eoi_cmd_valid = 1'b0;
        model_step(-1, 1'b1, cmd, lvl, -1);
        check_state("ocw2");
    endtask

    task automatic do_ack(input logic [7:0] irq, input bit drop, input bit aeoi,
                          input logic [4:0] base, input bit ocw, input logic [2:0] cmd,
                          input logic [2:0] lvl, input bit abort);
        int         level;
        bit         spur;
        logic [7:0] bitv;
        bus.auto_eoi    = aeoi;
        bus.vector_base = base;
        bus.interrupt   = irq;
        tick(1);
        check("int_out_raised", 32'(bus.int_out), 1);
        if (drop) bus.interrupt = 8'h00;
        bus.inta_n = 1'b0;
        if (ocw) begin
            bus.eoi_cmd_valid = 1'b1;
            bus.eoi_cmd       = cmd;
            bus.eoi_level     = lvl;
        end
        tick(1);
        bus.eoi_cmd_valid = 1'b0;
        bus.interrupt     = 8'h00;
        spur  = drop || (irq == 8'h00);
        level = 7;
        if (!spur)
            for (int i = 0; i < 8; i++) if (irq[i]) level = i;
        model_step(spur ? -1 : level, ocw, cmd, lvl, -1);
        if (!spur) begin
            bitv        = 8'h00;
            bitv[level] = 1'b1;
            exp_clr_q.push_back(bitv);
        end
        check("int_out_dropped", 32'(bus.int_out), 0);
        check("isr_after_pulse1", 32'(bus.in_service_register), 32'(m_isr));
        check("no_vector_pulse1", 32'(bus.data_out_en), 0);
        tick($urandom_range(0, 2));
        bus.inta_n = 1'b1;
        tick(1 + $urandom_range(0, 2));
        if (abort) return;
        exp_vec_q.push_back({base, 3'(level)});
        bus.inta_n = 1'b0;
        tick(1);
        check("vector_enable", 32'(bus.data_out_en), 1);
        tick($urandom_range(0, 2));
        bus.inta_n = 1'b1;
        tick(1);
        model_step(-1, 1'b0, 3'd0, 3'd0, (aeoi && !spur) ? level : -1);
        check("vector_release", 32'(bus.data_out_en), 0);
        check_state("after_pulse2");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_int_out"}, 32'(bus.int_out), 0);
        check({tag, "_isr"}, 32'(bus.in_service_register), 0);
        check({tag, "_rotate"}, 32'(bus.priority_rotate), 7);
        check({tag, "_data_out_en"}, 32'(bus.data_out_en), 0);
        check({tag, "_clear_irr"}, 32'(bus.clear_irr), 0);
        check({tag, "_data_out"}, 32'(bus.data_out), 0);
    endtask

    // Monitor: every clear_irr pulse and every vector presentation must match the next expectation.
    initial begin : monitor
        logic en_prev;
        en_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.clear_irr != 8'h00) begin
                if (exp_clr_q.size() == 0) check("clear_irr_unexpected", 32'(bus.clear_irr), 0);
                else check("clear_irr", 32'(bus.clear_irr), 32'(exp_clr_q.pop_front()));
            end
            if (bus.data_out_en && !en_prev) begin
                if (exp_vec_q.size() == 0) check("vector_unexpected", 32'(bus.data_out_en), 0);
                else check("vector", 32'(bus.data_out), 32'(exp_vec_q.pop_front()));
            end
            en_prev = bus.data_out_en;
        end
    end

    initial begin : stimulus
        logic [7:0] irq;
        reset_n           = 1'b0;
        bus.interrupt     = 8'h00;
        bus.inta_n        = 1'b1;
        bus.vector_base   = 5'd0;
        bus.auto_eoi      = 1'b0;
        bus.eoi_cmd_valid = 1'b0;
        bus.eoi_cmd       = 3'd0;
        bus.eoi_level     = 3'd0;
        model_reset();
        tick(3);
        check_reset_values("reset");
        reset_n = 1'b1;

        // Reset arriving while waiting for the second INTA pulse.
        do_ack(8'h01, 1'b0, 1'b0, 5'b00110, 1'b0, 3'd0, 3'd0, 1'b1);
        reset_n = 1'b0;
        #2;
        check_reset_values("abort");
        model_reset();
        tick(1);
        reset_n = 1'b1;

        do_ack(8'h08, 1'b0, 1'b0, 5'b01000, 1'b0, 3'd0, 3'd0, 1'b0);
        do_ack(8'h02, 1'b0, 1'b0, 5'b01000, 1'b0, 3'd0, 3'd0, 1'b0);
        do_ocw(3'b001, 3'd0);
        do_ocw(3'b101, 3'd0);

        do_ocw(3'b110, 3'd7);
        do_ocw(3'b100, 3'd0);
        do_ack(8'h20, 1'b0, 1'b1, 5'b11001, 1'b0, 3'd0, 3'd0, 1'b0);
        do_ocw(3'b000, 3'd0);

        do_ack(8'h04, 1'b1, 1'b0, 5'b10101, 1'b0, 3'd0, 3'd0, 1'b0);
        do_ocw(3'b001, 3'd0);

        // Specific EOI on the level being acknowledged in the same cycle: the set must win.
        do_ack(8'h01, 1'b0, 1'b0, 5'b00011, 1'b1, 3'b011, 3'd0, 1'b0);
        do_ocw(3'b011, 3'd0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 6) begin
                irq = 8'h00;
                irq[$urandom_range(0, 7)] = 1'b1;
                do_ack(irq, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                       5'($urandom), ($urandom_range(0, 5) == 0), 3'($urandom), 3'($urandom),
                       1'b0);
            end else begin
                do_ocw(3'($urandom), 3'($urandom));
            end
            tick($urandom_range(0, 2));
        end

        tick(3);
        check("clr_queue_drained", 32'(exp_clr_q.size()), 0);
        check("vec_queue_drained", 32'(exp_vec_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
